pll_lock_sequencer: RTL and testbench

Consumer-side counterpart to the PLL reset/lock-calibration wrapper. Runs on the free-running reference clock (the PLL init clock). It drives the PLL reset request and watches the raw PLL lock, qualifying it for stability. It then releases per-output clock enables (enclk) one at a time, deasserts the system reset request last, and recovers automatically on lock timeout or lock loss.

---
 rtl/pll_lock_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, qualifies the synchronized lock,
// then releases clock enables one at a time and finally the system reset.
module pll_lock_sequencer #(
  parameter int NUM_CLKS       = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int ENABLE_GAP     = 8,
  parameter int RELEASE_DELAY  = 16,
  parameter int RETRY_W        = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pll_lock_i,
  output logic                pll_rst_o,
  output logic [NUM_CLKS-1:0] clk_en_o,
  output logic                sys_rst_no,
  output logic                locked_o,
  output logic [RETRY_W-1:0]  retry_cnt_o,
  output logic                lock_lost_o
);

  // state        | meaning
  // ST_RST_PLL   | PLL held in reset for PLL_RST_CYCLES
  // ST_WAIT_LOCK | waiting for lock, retry after LOCK_TIMEOUT
  // ST_STABLE    | lock must stay high for STABLE_CYCLES
  // ST_ENABLE    | raising clock enables ENABLE_GAP apart
  // ST_RELEASE   | RELEASE_DELAY before system reset release
  // ST_RUN       | locked, outputs held
  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_ENABLE,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (STABLE_CYCLES > ENABLE_GAP) ? STABLE_CYCLES : ENABLE_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > RELEASE_DELAY) ? MAX_C : RELEASE_DELAY;
  localparam int CNT_W = $clog2(MAX_P + 1);
  localparam int IDX_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;

  if (NUM_CLKS < 1 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || STABLE_CYCLES < 1 ||
      ENABLE_GAP < 1 || RELEASE_DELAY < 1 || RETRY_W < 1) begin : g_param_check
    $error("pll_lock_sequencer: illegal parameter value");
  end

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_lock_meta;
  logic                r_lock_s;
  logic                r_pll_rst;
  logic [NUM_CLKS-1:0] r_clk_en;
  logic                r_sys_rst_n;
  logic                r_locked;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_lock_lost;
  logic                w_lock_lost;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_lock_lost = !r_lock_s &&
                       (r_state inside {ST_STABLE, ST_ENABLE, ST_RELEASE, ST_RUN});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RST_PLL;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pll_rst   <= 1'b1;
      r_clk_en    <= '0;
      r_sys_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_retry     <= '0;
      r_lock_lost <= 1'b0;
    end else if (w_lock_lost) begin
      // enables drop now; PLL reset rises on the following edge
      r_clk_en    <= '0;
      r_sys_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b1;
      r_cnt       <= '0;
      r_state     <= ST_RST_PLL;
    end else begin
      case (r_state)
        ST_RST_PLL: begin
          r_clk_en    <= '0;
          r_sys_rst_n <= 1'b0;
          r_locked    <= 1'b0;
          if (!r_pll_rst) begin
            r_pll_rst <= 1'b1;
          end else if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            r_pll_rst <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_cnt   <= '0;
            r_state <= ST_STABLE;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_state   <= ST_RST_PLL;
            if (r_retry != {RETRY_W{1'b1}}) r_retry <= r_retry + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= ST_ENABLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ENABLE: begin
          if (r_cnt == '0 || r_cnt == CNT_W'(ENABLE_GAP)) begin
            r_clk_en[r_idx] <= 1'b1;
            if (r_idx == IDX_W'(NUM_CLKS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_RELEASE;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_cnt <= CNT_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(RELEASE_DELAY - 1)) begin
            r_sys_rst_n <= 1'b1;
            r_locked    <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_RST_PLL;
        end
      endcase
    end
  end

  assign pll_rst_o   = r_pll_rst;
  assign clk_en_o    = r_clk_en;
  assign sys_rst_no  = r_sys_rst_n;
  assign locked_o    = r_locked;
  assign retry_cnt_o = r_retry;
  assign lock_lost_o = r_lock_lost;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock patterns,
// checked every cycle against a timeline model of the expected outputs.
module tb_pll_lock_sequencer;
  localparam int P = 4, T = 32, S = 8, G = 3, R = 5, N = 2, RW = 4;
  localparam int PH_RST = 0, PH_WAIT = 1, PH_QUAL = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          pll_lock_i = 1'b0;
  logic          pll_rst_o;
  logic [N-1:0]  clk_en_o;
  logic          sys_rst_no;
  logic          locked_o;
  logic [RW-1:0] retry_cnt_o;
  logic          lock_lost_o;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase, edges since phase entry, late PLL-reset start after a loss
  int ph, n, late, m_retry;
  bit m_lost, m_s1, m_s2;
  logic         e_rst;
  logic [N-1:0] e_en;
  logic         e_sys;
  bit           en_seen;
  bit           reached;

  pll_lock_sequencer #(
    .NUM_CLKS(N), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S),
    .ENABLE_GAP(G), .RELEASE_DELAY(R), .RETRY_W(RW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pll_lock_i(pll_lock_i),
    .pll_rst_o(pll_rst_o), .clk_en_o(clk_en_o), .sys_rst_no(sys_rst_no),
    .locked_o(locked_o), .retry_cnt_o(retry_cnt_o), .lock_lost_o(lock_lost_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = PH_RST; n = 0; late = 0; m_retry = 0; m_lost = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge(input bit l);
    n++;
    case (ph)
      PH_RST: if (n == P + late) begin ph = PH_WAIT; n = 0; end
      PH_WAIT: begin
        if (l) begin
          ph = PH_QUAL; n = 0;
        end else if (n == T) begin
          ph = PH_RST; n = 0; late = 0;
          if (m_retry < (1 << RW) - 1) m_retry++;
        end
      end
      default: if (!l) begin ph = PH_RST; n = 0; late = 1; m_lost = 1; end
    endcase
  endtask

  task automatic model_outputs();
    e_rst = 1'b0; e_en = '0; e_sys = 1'b0;
    if (ph == PH_RST) begin
      e_rst = (n >= late);
    end else if (ph == PH_QUAL) begin
      for (int i = 0; i < N; i++) e_en[i] = (n >= S + 1 + i * G);
      e_sys = (n >= S + 1 + (N - 1) * G + R);
    end
  endtask

  task automatic compare_all();
    model_outputs();
    check_val("pll_rst", 32'(pll_rst_o), 32'(e_rst));
    check_val("clk_en", 32'(clk_en_o), 32'(e_en));
    check_val("sys_rst_n", 32'(sys_rst_no), 32'(e_sys));
    check_val("locked", 32'(locked_o), 32'(e_sys));
    check_val("retry", 32'(retry_cnt_o), 32'(m_retry));
    check_val("lock_lost", 32'(lock_lost_o), 32'(m_lost));
    if (clk_en_o != '0) en_seen = 1'b1;
  endtask

  // starts and ends just after a falling edge
  task automatic step(input bit lk);
    bit l;
    pll_lock_i = lk;
    @(posedge clk_i);
    l = m_s2; m_s2 = m_s1; m_s1 = lk;
    model_edge(l);
    #1 compare_all();
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // nominal bring-up: lock 10 cycles after reset release
    apply_reset();
    repeat (10) step(1'b0);
    repeat (40) step(1'b1);
    check_val("a_locked", 32'(locked_o), 32'd1);
    check_val("a_retry", 32'(retry_cnt_o), 32'd0);

    // lock loss in RUN, then relock
    repeat (15) step(1'b0);
    repeat (60) step(1'b1);
    check_val("d_lost", 32'(lock_lost_o), 32'd1);
    check_val("d_relocked", 32'(locked_o), 32'd1);

    // no lock at all: retries saturate
    apply_reset();
    repeat (36 * 17) step(1'b0);
    check_val("b_retry_sat", 32'(retry_cnt_o), 32'd15);

    // single-cycle glitch during stability qualification
    apply_reset();
    en_seen = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (ph == PH_QUAL && n == 5) reached = 1'b1;
      else step(1'b1);
    end
    check_val("c_reach", 32'(reached), 32'd1);
    step(1'b0);
    repeat (3) step(1'b1);
    check_val("c_lost", 32'(lock_lost_o), 32'd1);
    check_val("c_retry", 32'(retry_cnt_o), 32'd0);
    check_val("c_no_en", 32'(en_seen), 32'd0);
    repeat (40) step(1'b1);

    // async reset with only the first enable raised
    apply_reset();
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      model_outputs();
      if (ph == PH_QUAL && e_en == 2'b01) reached = 1'b1;
      else step(1'b1);
    end
    check_val("e_reach", 32'(reached), 32'd1);
    check_val("e_pre_en", 32'(clk_en_o), 32'd1);
    apply_reset();
    repeat (50) step(1'b1);
    check_val("e_relocked", 32'(locked_o), 32'd1);

    // lock first seen on the final timeout cycle
    apply_reset();
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      if (ph == PH_WAIT && n == T - 3) reached = 1'b1;
      else step(1'b0);
    end
    check_val("f_reach", 32'(reached), 32'd1);
    repeat (40) step(1'b1);
    check_val("f_retry", 32'(retry_cnt_o), 32'd0);
    check_val("f_locked", 32'(locked_o), 32'd1);

    // random lock patterns with occasional glitches and resets
    apply_reset();
    for (int r = 0; r < 30; r++) begin
      int lo_len, hi_len;
      if ($urandom_range(0, 5) == 0) apply_reset();
      lo_len = int'($urandom_range(0, 45));
      hi_len = int'($urandom_range(1, 50));
      repeat (lo_len) step(1'b0);
      for (int k = 0; k < hi_len; k++) step($urandom_range(0, 11) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
